// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
//   Produces a pixel-clock enable, h/v pixel counters, sync pulses, a display-enable window,
//   line/frame start pulses and a completed-frame counter. Runs only while requested; a frame
//   that has started always runs to completion before the generator goes idle.
// Ports:
//   clk          system clock
//   reset        asynchronous reset, active low
//   en           run request, acted on only when idle or at the end of a frame
//   p_tick       one-clk pixel enable every CLK_DIV clks
//   hsync/vsync  sync outputs, active level H_POL / V_POL
//   de           visible-area indicator
//   pixel_x/y    current pixel position
//   line_start   one-clk pulse on entering column 0 while running
//   frame_start  one-clk pulse on entering (0,0) while running
//   frame_cnt    completed-frame counter, wraps at 256
module vga_timing_gen #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_DISP  = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33,
  parameter int unsigned H_POL   = 0,
  parameter int unsigned V_POL   = 0,
  parameter int unsigned CW      = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);

  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DivLast   = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HLast     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HDispLast = CW'(H_DISP - 1);
  localparam logic [CW-1:0] VDispLast = CW'(V_DISP - 1);
  // Inclusive bounds: an exclusive end of H_TOTAL might not fit in CW bits.
  localparam logic [CW-1:0] HsFirst   = CW'(H_DISP + H_FP);
  localparam logic [CW-1:0] HsLast    = CW'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VsFirst   = CW'(V_DISP + V_FP);
  localparam logic [CW-1:0] VsLast    = CW'(V_DISP + V_FP + V_SYNC - 1);
  localparam logic          HActive   = (H_POL != 0);
  localparam logic          VActive   = (V_POL != 0);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          p_tick_q, p_tick_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic          ls_q, ls_d, fs_q, fs_d;
  logic          run_d;

  always_comb begin
    div_d    = (div_q == DivLast) ? '0 : div_q + 1'b1;
    // Registered so p_tick is high exactly while div_q == CLK_DIV-1 and low in reset.
    p_tick_d = (div_d == DivLast);

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    fcnt_d  = fcnt_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;

    if (p_tick_q) begin
      unique case (state_q)
        StIdle: begin
          if (en) begin
            state_d = StRun;
            x_d     = '0;
            y_d     = '0;
            ls_d    = 1'b1;
            fs_d    = 1'b1;
          end
        end
        StRun: begin
          if (x_q != HLast) begin
            x_d = x_q + 1'b1;
          end else begin
            x_d  = '0;
            ls_d = 1'b1;
            if (y_q != VLast) begin
              y_d = y_q + 1'b1;
            end else begin
              // Frame end: en is only honoured here, so frames are never truncated.
              fcnt_d = fcnt_q + 8'd1;
              y_d    = '0;
              if (en) begin
                fs_d = 1'b1;
              end else begin
                state_d = StIdle;
                ls_d    = 1'b0;
              end
            end
          end
        end
      endcase
    end

    // Decode from next-state so every output describes the pixel being entered.
    run_d   = (state_d == StRun);
    de_d    = run_d && (x_d <= HDispLast) && (y_d <= VDispLast);
    hsync_d = (run_d && (x_d >= HsFirst) && (x_d <= HsLast)) ? HActive : ~HActive;
    vsync_d = (run_d && (y_d >= VsFirst) && (y_d <= VsLast)) ? VActive : ~VActive;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      div_q    <= '0;
      p_tick_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      fcnt_q   <= '0;
      hsync_q  <= ~HActive;
      vsync_q  <= ~VActive;
      de_q     <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      p_tick_q <= p_tick_d;
      x_q      <= x_d;
      y_q      <= y_d;
      fcnt_q   <= fcnt_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  assign p_tick      = p_tick_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-geometry instances (H 8/2/2/2, V 4/1/1/1).
//   A: CLK_DIV=3, active-low syncs.  B: CLK_DIV=1, active-high syncs.
module tb_vga_timing_gen;

  localparam int HT = 14;
  localparam int VT = 7;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_a, en_b;
  logic       pt_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic       pt_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [3:0] x_a, y_a, x_b, y_b;
  logic [7:0] fcnt_a, fcnt_b;

  int n_vec = 0;
  int n_err = 0;

  pix_t q_a[$];
  pix_t q_b[$];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(3), .H_DISP(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(0), .V_POL(0), .CW(4)
  ) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .p_tick(pt_a), .hsync(hs_a), .vsync(vs_a),
    .de(de_a), .pixel_x(x_a), .pixel_y(y_a), .line_start(ls_a), .frame_start(fs_a),
    .frame_cnt(fcnt_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISP(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1), .CW(4)
  ) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .p_tick(pt_b), .hsync(hs_b), .vsync(vs_b),
    .de(de_b), .pixel_x(x_b), .pixel_y(y_b), .line_start(ls_b), .frame_start(fs_b),
    .frame_cnt(fcnt_b)
  );

  // Reference: sync columns 10..11, sync line 5, visible area x<8, y<4.
  function automatic pix_t model(int x, int y, bit run, bit pol, bit ls, bit fs);
    pix_t p;
    p.x  = 4'(x);
    p.y  = 4'(y);
    p.hs = (run && x >= 10 && x < 12) ? pol : !pol;
    p.vs = (run && y == 5) ? pol : !pol;
    p.de = run && x < 8 && y < 4;
    p.ls = ls;
    p.fs = fs;
    return p;
  endfunction

  function automatic pix_t obs_a();
    return {x_a, y_a, hs_a, vs_a, de_a, ls_a, fs_a};
  endfunction

  function automatic pix_t obs_b();
    return {x_b, y_b, hs_b, vs_b, de_b, ls_b, fs_b};
  endfunction

  function automatic string fmt(pix_t p);
    return $sformatf("(x%0d y%0d hs%b vs%b de%b ls%b fs%b)", p.x, p.y, p.hs, p.vs, p.de, p.ls,
                     p.fs);
  endfunction

  // Advance to the negedge just after A's next tick edge.
  task automatic tick_a();
    int k = 0;
    while (pt_a !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (pt_a !== 1'b1) begin
      n_err++;
      $display("FAIL tick_a_timeout: p_tick=%b, required 1 within 8 clk", pt_a);
    end
    @(negedge clk);
  endtask

  task automatic tick_b();
    int k = 0;
    while (pt_b !== 1'b1 && k < 4) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (pt_b !== 1'b1) begin
      n_err++;
      $display("FAIL tick_b_timeout: p_tick=%b, required 1", pt_b);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    pix_t ea, eb;
    ea = model(0, 0, 0, 0, 0, 0);
    eb = model(0, 0, 0, 1, 0, 0);
    n_vec++;
    if (obs_a() !== ea) begin
      n_err++;
      $display("FAIL reset_a: got %s want %s", fmt(obs_a()), fmt(ea));
    end
    n_vec++;
    if (obs_b() !== eb) begin
      n_err++;
      $display("FAIL reset_b: got %s want %s", fmt(obs_b()), fmt(eb));
    end
    n_vec++;
    if (pt_a !== 1'b0 || pt_b !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ptick: got a=%b b=%b want 0 0", pt_a, pt_b);
    end
    n_vec++;
    if (fcnt_a !== 8'd0 || fcnt_b !== 8'd0) begin
      n_err++;
      $display("FAIL reset_fcnt: got a=%0d b=%0d want 0 0", fcnt_a, fcnt_b);
    end
  endtask

  task automatic test_idle();
    pix_t e;
    reset = 1'b1;
    e = model(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick_a();
      n_vec++;
      if (obs_a() !== e) begin
        n_err++;
        $display("FAIL idle_hold: got %s want %s", fmt(obs_a()), fmt(e));
      end
    end
  endtask

  task automatic test_frame();
    pix_t e, o;
    int de_cnt = 0;
    for (int y = 0; y < VT; y++)
      for (int x = 0; x < HT; x++) q_a.push_back(model(x, y, 1, 0, x == 0, x == 0 && y == 0));
    q_a.push_back(model(0, 0, 1, 0, 1, 1));
    en_a = 1'b1;
    for (int i = 0; i < HT * VT + 1; i++) begin
      tick_a();
      o = obs_a();
      e = q_a.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL frame_pix[%0d]: got %s want %s", i, fmt(o), fmt(e));
      end
      if (i < HT * VT && o.de) de_cnt++;
      if (i == 0) begin
        @(negedge clk);
        n_vec++;
        if (ls_a !== 1'b0 || fs_a !== 1'b0 || x_a !== 4'd0) begin
          n_err++;
          $display("FAIL pulse_width: got ls=%b fs=%b x=%0d want 0 0 0", ls_a, fs_a, x_a);
        end
      end
    end
    n_vec++;
    if (de_cnt !== 32) begin
      n_err++;
      $display("FAIL de_count: got %0d want 32", de_cnt);
    end
    n_vec++;
    if (fcnt_a !== 8'd1) begin
      n_err++;
      $display("FAIL frame_cnt_1: got %0d want 1", fcnt_a);
    end
  endtask

  task automatic test_stop();
    pix_t e, o;
    int k;
    for (int i = 1; i < HT * VT; i++) q_a.push_back(model(i % HT, i / HT, 1, 0, i % HT == 0, 0));
    q_a.push_back(model(0, 0, 0, 0, 0, 0));
    while (q_a.size() > 0) begin
      tick_a();
      o = obs_a();
      e = q_a.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL stop_pix: got %s want %s", fmt(o), fmt(e));
      end
      if (e.x == 4'd0 && e.y == 4'd2) en_a = 1'b0;
    end
    n_vec++;
    if (fcnt_a !== 8'd2) begin
      n_err++;
      $display("FAIL frame_cnt_2: got %0d want 2", fcnt_a);
    end
    e = model(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick_a();
      n_vec++;
      if (obs_a() !== e) begin
        n_err++;
        $display("FAIL stop_idle: got %s want %s", fmt(obs_a()), fmt(e));
      end
    end
    en_a = 1'b1;
    k = 0;
    while (fs_a !== 1'b1 && k < 3) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (fs_a !== 1'b1 || x_a !== 4'd0 || y_a !== 4'd0) begin
      n_err++;
      $display("FAIL restart_latency: got fs=%b x=%0d y=%0d after %0d clk want fs=1 at (0,0)",
               fs_a, x_a, y_a, k);
    end
  endtask

  task automatic test_reset_mid();
    pix_t e;
    int k;
    for (int i = 0; i < 4; i++) tick_a();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    e = model(0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs_a() !== e || pt_a !== 1'b0 || fcnt_a !== 8'd0) begin
      n_err++;
      $display("FAIL reset_mid: got %s pt=%b fcnt=%0d want %s pt=0 fcnt=0", fmt(obs_a()), pt_a,
               fcnt_a, fmt(e));
    end
    @(negedge clk);
    reset = 1'b1;
    k = 0;
    while (fs_a !== 1'b1 && k < 6) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k !== 3 || fs_a !== 1'b1 || x_a !== 4'd0 || y_a !== 4'd0) begin
      n_err++;
      $display("FAIL reset_restart: got fs=%b x=%0d y=%0d after %0d clk want fs=1 (0,0) after 3",
               fs_a, x_a, y_a, k);
    end
  endtask

  task automatic test_polarity();
    pix_t e, o;
    int pt_low = 0;
    for (int y = 0; y < VT; y++)
      for (int x = 0; x < HT; x++) q_b.push_back(model(x, y, 1, 1, x == 0, x == 0 && y == 0));
    q_b.push_back(model(0, 0, 1, 1, 1, 1));
    en_b = 1'b1;
    while (q_b.size() > 0) begin
      tick_b();
      o = obs_b();
      e = q_b.pop_front();
      if (pt_b !== 1'b1) pt_low++;
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL pol_pix: got %s want %s", fmt(o), fmt(e));
      end
    end
    n_vec++;
    if (pt_low !== 0) begin
      n_err++;
      $display("FAIL ptick_const: got %0d low samples want 0", pt_low);
    end
    n_vec++;
    if (fcnt_b !== 8'd1) begin
      n_err++;
      $display("FAIL pol_fcnt: got %0d want 1", fcnt_b);
    end
  endtask

  task automatic test_wrap();
    int k;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    en_b  = 1'b1;
    for (int n = 0; n <= 256; n++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (fs_b !== 1'b1 && k < 120);
      n_vec++;
      if (fs_b !== 1'b1 || fcnt_b !== 8'(n)) begin
        n_err++;
        $display("FAIL wrap_fcnt[%0d]: got fs=%b fcnt=%0d want fs=1 fcnt=%0d", n, fs_b, fcnt_b,
                 n % 256);
      end
      if (n > 0) begin
        n_vec++;
        if (k !== HT * VT) begin
          n_err++;
          $display("FAIL wrap_period[%0d]: got %0d clk want %0d", n, k, HT * VT);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_idle();
    test_frame();
    test_stop();
    test_reset_mid();
    test_polarity();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, vectors=%0d", n_vec);
    $fatal(1);
  end

endmodule
